// File: rtl/tri_edge_sequencer_if.sv
// tri_edge_sequencer_if
//   Triangle command channel between a command source and the triangle edge
//   sequencer. One triangle (three vertices) moves per cmd_valid & cmd_ready.
//
//   cmd_valid        source -> sequencer  triangle command valid
//   cmd_ready        sequencer -> source  sequencer can accept a triangle
//   v0x, v1x, v2x    source -> sequencer  vertex x coordinates (10 bit, unsigned)
//   v0y, v1y, v2y    source -> sequencer  vertex y coordinates (9 bit, unsigned)
//
//   master: command source side, slave: sequencer side.
interface tri_edge_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] v0x;
  logic [9:0] v1x;
  logic [9:0] v2x;
  logic [8:0] v0y;
  logic [8:0] v1y;
  logic [8:0] v2y;

  modport master (
    output cmd_valid,
    output v0x, v1x, v2x,
    output v0y, v1y, v2y,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  v0x, v1x, v2x,
    input  v0y, v1y, v2y,
    output cmd_ready
  );
endinterface

// File: rtl/tri_edge_sequencer.sv
// tri_edge_sequencer
//   Triangle front-end for a Bresenham line engine. Accepts one triangle per
//   command handshake and draws its edges v0->v1, v1->v2, v2->v0 in turn.
//   Each edge is normalised so that x never decreases; the engine only steps
//   +x/+y, so an edge whose normalised y decreases is skipped and flagged.
//   While an edge is drawing, engine pixels are forwarded to the framebuffer
//   writer. A watchdog aborts any edge whose engine never reports finish.
//
//   Parameters
//     TIMEOUT  max WAIT cycles per edge before it is aborted (>= 4)
//     CW       wait-counter width, 2**CW > TIMEOUT
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     cmd (slave modport)        triangle command channel (valid/ready + vertices)
//     ln_start                   one-cycle engine start strobe
//     ln_x1, ln_y1, ln_x2, ln_y2 normalised edge endpoints, zero-extended
//     ln_x, ln_y, ln_finish      engine current pixel and done level
//     px_valid, px_x, px_y       pixel write strobe and coordinates
//     busy                       high whenever not idle
//     done                       one-cycle pulse at triangle completion
//     err_slope, err_timeout     sticky error flags, cleared on the next command
module tri_edge_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tri_edge_sequencer_if.slave        cmd,
  output logic                       ln_start,
  output logic [31:0]                ln_x1,
  output logic [31:0]                ln_y1,
  output logic [31:0]                ln_x2,
  output logic [31:0]                ln_y2,
  input  logic [9:0]                 ln_x,
  input  logic [8:0]                 ln_y,
  input  logic                       ln_finish,
  output logic                       px_valid,
  output logic [9:0]                 px_x,
  output logic [8:0]                 px_y,
  output logic                       busy,
  output logic                       done,
  output logic                       err_slope,
  output logic                       err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The engine's finish level and coordinates still reflect the previous
  // edge for the first two WAIT cycles, so both are ignored until then.
  localparam logic [CW-1:0] GUARD_CNT = CW'(2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [1:0]    edge_idx;
  logic [CW-1:0] wait_cnt;

  logic [9:0] vx0, vx1, vx2;
  logic [8:0] vy0, vy1, vy2;

  logic [9:0] a_x, b_x, p1_x, p2_x;
  logic [8:0] a_y, b_y, p1_y, p2_y;

  logic engine_live;

  // Endpoint selection for the current edge, then ordering by x. On an x tie
  // the original order is kept, which decides whether a vertical edge is
  // drawn or skipped as a falling edge.
  always_comb begin
    a_x = vx0;
    a_y = vy0;
    b_x = vx1;
    b_y = vy1;
    case (edge_idx)
      2'd1: begin
        a_x = vx1;
        a_y = vy1;
        b_x = vx2;
        b_y = vy2;
      end
      2'd2: begin
        a_x = vx2;
        a_y = vy2;
        b_x = vx0;
        b_y = vy0;
      end
      default: begin
        a_x = vx0;
        a_y = vy0;
        b_x = vx1;
        b_y = vy1;
      end
    endcase
    if (a_x > b_x) begin
      p1_x = b_x;
      p1_y = b_y;
      p2_x = a_x;
      p2_y = a_y;
    end else begin
      p1_x = a_x;
      p1_y = a_y;
      p2_x = b_x;
      p2_y = b_y;
    end
  end

  assign engine_live   = (state == S_WAIT) && (wait_cnt >= GUARD_CNT);
  assign px_valid      = engine_live && !ln_finish;
  assign px_x          = ln_x;
  assign px_y          = ln_y;
  assign busy          = (state != S_IDLE);
  assign cmd.cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      edge_idx    <= 2'd0;
      wait_cnt    <= '0;
      vx0         <= '0;
      vx1         <= '0;
      vx2         <= '0;
      vy0         <= '0;
      vy1         <= '0;
      vy2         <= '0;
      ln_start    <= 1'b0;
      ln_x1       <= '0;
      ln_y1       <= '0;
      ln_x2       <= '0;
      ln_y2       <= '0;
      done        <= 1'b0;
      err_slope   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ln_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            vx0         <= cmd.v0x;
            vx1         <= cmd.v1x;
            vx2         <= cmd.v2x;
            vy0         <= cmd.v0y;
            vy1         <= cmd.v1y;
            vy2         <= cmd.v2y;
            edge_idx    <= 2'd0;
            err_slope   <= 1'b0;
            err_timeout <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          ln_x1 <= {22'd0, p1_x};
          ln_y1 <= {23'd0, p1_y};
          ln_x2 <= {22'd0, p2_x};
          ln_y2 <= {23'd0, p2_y};
          if (p2_y < p1_y) begin
            err_slope <= 1'b1;
            state     <= S_NEXT;
          end else begin
            // Raised here so the strobe is high for exactly the START cycle.
            ln_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          // Finish is tested first so that it wins over a same-cycle timeout.
          if (ln_finish && engine_live) begin
            state <= S_NEXT;
          end else if (wait_cnt == LAST_CNT) begin
            err_timeout <= 1'b1;
            state       <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (edge_idx == 2'd2) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            edge_idx <= edge_idx + 2'd1;
            state    <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// tb_tri_edge_sequencer
//   Self-checking bench for tri_edge_sequencer (TIMEOUT=16). A behavioural
//   Bresenham engine answers ln_start; per triangle the expected endpoints,
//   latency, pixel count and error flags are worked out from the edge rules.
module tb_tri_edge_sequencer;

  localparam int TMO = 16;
  localparam int CWB = 5;

  logic        clk;
  logic        rst_n;
  logic        ln_start;
  logic [31:0] ln_x1, ln_y1, ln_x2, ln_y2;
  logic [9:0]  ln_x;
  logic [8:0]  ln_y;
  logic        ln_finish;
  logic        px_valid;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic        busy, done, err_slope, err_timeout;

  tri_edge_sequencer_if cmd_if();

  tri_edge_sequencer #(.TIMEOUT(TMO), .CW(CWB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .ln_start    (ln_start),
    .ln_x1       (ln_x1),
    .ln_y1       (ln_y1),
    .ln_x2       (ln_x2),
    .ln_y2       (ln_y2),
    .ln_x        (ln_x),
    .ln_y        (ln_y),
    .ln_finish   (ln_finish),
    .px_valid    (px_valid),
    .px_x        (px_x),
    .px_y        (px_y),
    .busy        (busy),
    .done        (done),
    .err_slope   (err_slope),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Behavioural line engine: two cycles of start-up, then one Bresenham pixel
  // per cycle, then finish. The previous finish level lingers one cycle after
  // a restart. In hang mode it reaches the end point and never finishes.
  bit hang = 1'b0;
  int ex, ey, tx, ty, edx, edy, eerr, edly;

  always @(posedge clk or negedge rst_n) begin : engine
    int e2, nerr;
    if (!rst_n) begin
      ex <= 0; ey <= 0; tx <= 0; ty <= 0;
      edx <= 0; edy <= 0; eerr <= 0; edly <= 0;
      ln_finish <= 1'b0;
    end else if (ln_start) begin
      ex   <= int'(ln_x1);
      ey   <= int'(ln_y1);
      tx   <= int'(ln_x2);
      ty   <= int'(ln_y2);
      edx  <= int'(ln_x2) - int'(ln_x1);
      edy  <= int'(ln_y2) - int'(ln_y1);
      eerr <= (int'(ln_x2) - int'(ln_x1)) - (int'(ln_y2) - int'(ln_y1));
      edly <= 2;
    end else if (edly != 0) begin
      edly <= edly - 1;
      if (edly == 2) ln_finish <= 1'b0;
    end else if (!ln_finish) begin
      if (ex == tx && ey == ty) begin
        ln_finish <= !hang;
      end else begin
        e2   = 2 * eerr;
        nerr = eerr;
        if (e2 >= -edy) begin
          ex   <= ex + 1;
          nerr = nerr - edy;
        end
        if (e2 <= edx) begin
          ey   <= ey + 1;
          nerr = nerr + edx;
        end
        eerr <= nerr;
      end
    end
  end

  assign ln_x = ex[9:0];
  assign ln_y = ey[8:0];

  // Passive monitor, sampling 1 time unit after the falling edge.
  int hs_cnt = 0, start_cnt = 0, px_cnt = 0, done_cnt = 0;
  logic [127:0] obs_q[$];

  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) hs_cnt++;
      if (ln_start) begin
        start_cnt++;
        obs_q.push_back({ln_x1, ln_y1, ln_x2, ln_y2});
      end
      if (px_valid) begin
        px_cnt++;
        checkOutput("px_passthru", {px_x, px_y}, {ln_x, ln_y});
      end
      if (done) done_cnt++;
    end
  end

  int last_hs_wait = 0;

  // Drives one triangle and checks it against the edge rules. With hold set,
  // cmd_valid stays high after the handshake (vertices are scrambled while
  // busy either way).
  task automatic applyStimulus(input string tag, input int x0, input int y0,
                               input int x1, input int y1, input int x2, input int y2,
                               input bit hang_mode, input bit hold);
    int vx[3];
    int vy[3];
    logic [127:0] exp_q[$];
    int exp_lat, exp_px, exp_starts;
    bit exp_slope, exp_to;
    int lat, hs0, st0, px0, dn0, hs_wait;

    vx = '{x0, x1, x2};
    vy = '{y0, y1, y2};
    exp_lat = 1;
    exp_px = 0;
    exp_slope = 1'b0;
    exp_to = 1'b0;
    for (int e = 0; e < 3; e++) begin
      int ax, ay, bx, by, t, n;
      ax = vx[e]; ay = vy[e];
      bx = vx[(e + 1) % 3]; by = vy[(e + 1) % 3];
      if (ax > bx) begin
        t = ax; ax = bx; bx = t;
        t = ay; ay = by; by = t;
      end
      if (by < ay) begin
        exp_slope = 1'b1;
        exp_lat += 2;
      end else begin
        n = ((bx - ax) > (by - ay) ? (bx - ax) : (by - ay)) + 1;
        exp_q.push_back({32'(ax), 32'(ay), 32'(bx), 32'(by)});
        // Engine finishes at wait count n+2; the watchdog fires at TMO-1.
        if (hang_mode || (n + 2 > TMO - 1)) begin
          exp_to = 1'b1;
          exp_lat += 3 + TMO;
          exp_px += TMO - 2;
        end else begin
          exp_lat += 3 + n + 3;
          exp_px += n;
        end
      end
    end
    exp_starts = exp_q.size();

    @(negedge clk);
    hang = hang_mode;
    hs0 = hs_cnt; st0 = start_cnt; px0 = px_cnt; dn0 = done_cnt;
    obs_q.delete();
    cmd_if.v0x = x0[9:0]; cmd_if.v0y = y0[8:0];
    cmd_if.v1x = x1[9:0]; cmd_if.v1y = y1[8:0];
    cmd_if.v2x = x2[9:0]; cmd_if.v2y = y2[8:0];
    cmd_if.cmd_valid = 1'b1;
    hs_wait = 0;
    while (!cmd_if.cmd_ready && hs_wait < 100) begin
      @(negedge clk);
      hs_wait++;
    end
    last_hs_wait = hs_wait;
    checkOutput({tag, "_handshake"}, cmd_if.cmd_ready, 1'b1);
    if (!cmd_if.cmd_ready) return;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmd_if.cmd_valid = hold;
        cmd_if.v0x = 10'($urandom); cmd_if.v0y = 9'($urandom);
        cmd_if.v1x = 10'($urandom); cmd_if.v1y = 9'($urandom);
        cmd_if.v2x = 10'($urandom); cmd_if.v2y = 9'($urandom);
        checkOutput({tag, "_ready_busy"}, {cmd_if.cmd_ready, busy}, 2'b01);
        checkOutput({tag, "_err_clear"}, {err_slope, err_timeout}, 2'b00);
      end
    end while (!done && lat < 500);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_errs"}, {err_slope, err_timeout}, {exp_slope, exp_to});
    checkOutput({tag, "_ready_done"}, cmd_if.cmd_ready, 1'b0);
    #2;
    checkOutput({tag, "_hs_count"}, hs_cnt - hs0, 1);
    checkOutput({tag, "_starts"}, start_cnt - st0, exp_starts);
    checkOutput({tag, "_pixels"}, px_cnt - px0, exp_px);
    checkOutput({tag, "_done_pulse"}, done_cnt - dn0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_edge%0d", tag, i),
                  (i < obs_q.size()) ? obs_q[i] : {128{1'b1}}, exp_q[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st_snap, lat;
    int bx, by;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.v0x = '0; cmd_if.v1x = '0; cmd_if.v2x = '0;
    cmd_if.v0y = '0; cmd_if.v1y = '0; cmd_if.v2y = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready_busy", {cmd_if.cmd_ready, busy}, 2'b10);
    checkOutput("rst_strobes", {ln_start, done, px_valid, err_slope, err_timeout}, 5'b0);
    checkOutput("rst_ln_pts", {ln_x1, ln_y1, ln_x2, ln_y2}, 128'd0);
    rst_n = 1'b1;

    // Reset mid-WAIT: edge 0 (0,10)->(5,0) is skipped, edge 1 draws (0,0)->(5,0).
    @(negedge clk);
    hang = 1'b0;
    cmd_if.v0x = 10'd0; cmd_if.v0y = 9'd10;
    cmd_if.v1x = 10'd5; cmd_if.v1y = 9'd0;
    cmd_if.v2x = 10'd0; cmd_if.v2y = 9'd0;
    cmd_if.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t1_pre_wait", {busy, px_valid, err_slope}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_ready_busy", {cmd_if.cmd_ready, busy}, 2'b10);
    checkOutput("t1_async_strobes", {ln_start, done, px_valid, err_slope, err_timeout}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    st_snap = start_cnt;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("t1_no_restart", {start_cnt - st_snap, 31'(busy)}, 64'd0);

    applyStimulus("t2_collinear", 0, 0, 5, 5, 10, 10, 1'b0, 1'b0);
    applyStimulus("t3_slope", 10, 10, 20, 10, 10, 20, 1'b0, 1'b0);
    applyStimulus("t4_hang", 0, 0, 3, 0, 3, 4, 1'b1, 1'b0);
    applyStimulus("t5_hold_a", 10, 10, 20, 10, 10, 20, 1'b0, 1'b1);
    applyStimulus("t5_hold_b", 40, 40, 45, 42, 50, 44, 1'b0, 1'b0);
    checkOutput("t5_back_to_back", last_hs_wait, 0);
    applyStimulus("t6_coincide", 100, 7, 112, 7, 112, 7, 1'b0, 1'b0);
    applyStimulus("t7_overrun", 200, 3, 213, 3, 213, 9, 1'b0, 1'b0);
    applyStimulus("t8_corner", 1009, 497, 1023, 511, 1016, 504, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      bx = $urandom_range(0, 1009);
      by = $urandom_range(0, 497);
      applyStimulus($sformatf("rnd%0d", r),
                    bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
